// File: rtl/mem_stage.sv
// MiniMIPS32 memory-access stage: data-RAM request/ack handshake, ack watchdog and MEM/WB register.
// Optional macro MEM_UNALIGNED_EXC_EN: misaligned word/half accesses raise adel_o/ades_o instead of being force-aligned.
module mem_stage #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst,
    input  logic        mem_valid_i,
    input  logic [7:0]  mem_aluop_i,
    input  logic [4:0]  mem_wa_i,
    input  logic        mem_wreg_i,
    input  logic        mem_whilo_i,
    input  logic        mem_mreg_i,
    input  logic [31:0] mem_wd_i,
    input  logic [31:0] mem_din_i,
    input  logic [63:0] mem_hilo_i,
    input  logic        flush_i,
    output logic        dreq_o,
    output logic [31:0] daddr_o,
    output logic [3:0]  dwe_o,
    output logic [3:0]  dre_o,
    output logic [31:0] dout_o,
    input  logic        dack_i,
    output logic        stall_req_o,
    output logic        timeout_o,
`ifdef MEM_UNALIGNED_EXC_EN
    output logic        adel_o,
    output logic        ades_o,
`endif
    output logic [7:0]  wb_aluop_o,
    output logic [4:0]  wb_wa_o,
    output logic        wb_wreg_o,
    output logic        wb_whilo_o,
    output logic        wb_mreg_o,
    output logic [31:0] wb_dreg_o,
    output logic [63:0] wb_dhilo_o,
    output logic [3:0]  wb_dre_o
);

    localparam logic [7:0] OP_LB  = 8'h90;
    localparam logic [7:0] OP_LBU = 8'h91;
    localparam logic [7:0] OP_LH  = 8'h92;
    localparam logic [7:0] OP_LHU = 8'h93;
    localparam logic [7:0] OP_LW  = 8'h94;
    localparam logic [7:0] OP_SB  = 8'h98;
    localparam logic [7:0] OP_SH  = 8'h99;
    localparam logic [7:0] OP_SW  = 8'h9A;
    localparam logic [15:0] WD_LAST = 16'(ACK_TIMEOUT - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    typedef struct packed {
        logic [7:0]  aluop;
        logic [4:0]  wa;
        logic        wreg;
        logic        whilo;
        logic        mreg;
        logic [31:0] dreg;
        logic [63:0] dhilo;
        logic [3:0]  dre;
    } wb_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        flushed_q, flushed_d;
    logic        timeout_q, timeout_d;
    wb_t         held_q, held_d, wb_q, wb_d, cur_wb_s;
    logic [31:0] req_addr_q, req_addr_d, req_dout_q, req_dout_d;
    logic [3:0]  req_we_q, req_we_d, req_re_q, req_re_d;
    logic        is_load_s, is_store_s, misal_s, start_s, exc_s, wd_fire_s;
    logic [3:0]  lanes_s;
    logic [31:0] sdata_s;
`ifdef MEM_UNALIGNED_EXC_EN
    logic        adel_q, adel_d, ades_q, ades_d;

    assign misal_s = (((mem_aluop_i == OP_LW) || (mem_aluop_i == OP_SW)) && (mem_wd_i[1:0] != 2'b00))
                   || (((mem_aluop_i == OP_LH) || (mem_aluop_i == OP_LHU) || (mem_aluop_i == OP_SH)) && mem_wd_i[0]);
    assign adel_o  = adel_q;
    assign ades_o  = ades_q;
`else
    assign misal_s = 1'b0;
`endif

    // Decode access type, lane mask (offset 0 = lane 4'b1000) and byte-swapped store data.
    always_comb begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
        lanes_s    = 4'b0000;
        sdata_s    = 32'h0000_0000;
        case (mem_aluop_i)
            OP_LB, OP_LBU: begin
                is_load_s = 1'b1;
                lanes_s   = 4'b1000 >> mem_wd_i[1:0];
            end
            OP_LH, OP_LHU: begin
                is_load_s = 1'b1;
                lanes_s   = mem_wd_i[1] ? 4'b0011 : 4'b1100;
            end
            OP_LW: begin
                is_load_s = 1'b1;
                lanes_s   = 4'b1111;
            end
            OP_SB: begin
                is_store_s = 1'b1;
                lanes_s    = 4'b1000 >> mem_wd_i[1:0];
                sdata_s    = {4{mem_din_i[7:0]}};
            end
            OP_SH: begin
                is_store_s = 1'b1;
                lanes_s    = mem_wd_i[1] ? 4'b0011 : 4'b1100;
                sdata_s    = {2{mem_din_i[7:0], mem_din_i[15:8]}};
            end
            OP_SW: begin
                is_store_s = 1'b1;
                lanes_s    = 4'b1111;
                sdata_s    = {mem_din_i[7:0], mem_din_i[15:8], mem_din_i[23:16], mem_din_i[31:24]};
            end
            default: begin
                is_load_s  = 1'b0;
                is_store_s = 1'b0;
            end
        endcase
    end

    assign start_s   = !cpu_rst && (state_q == S_IDLE) && mem_valid_i && !flush_i
                       && (is_load_s || is_store_s) && !misal_s;
    assign exc_s     = !cpu_rst && (state_q == S_IDLE) && mem_valid_i && !flush_i
                       && (is_load_s || is_store_s) && misal_s;
    assign wd_fire_s = (ACK_TIMEOUT != 0) && (state_q == S_WAIT) && (cnt_q == WD_LAST);

    // Snapshot of the instruction in this stage as it would enter MEM/WB.
    always_comb begin
        cur_wb_s.aluop = mem_aluop_i;
        cur_wb_s.wa    = mem_wa_i;
        cur_wb_s.wreg  = mem_wreg_i;
        cur_wb_s.whilo = mem_whilo_i;
        cur_wb_s.mreg  = mem_mreg_i;
        cur_wb_s.dreg  = mem_wd_i;
        cur_wb_s.dhilo = mem_hilo_i;
        cur_wb_s.dre   = is_load_s ? lanes_s : 4'b0000;
    end

    // RAM request: live from the decode on entry, then from the captured copy until the ack.
    always_comb begin
        if (state_q == S_WAIT) begin
            dreq_o  = 1'b1;
            daddr_o = req_addr_q;
            dwe_o   = req_we_q;
            dre_o   = req_re_q;
            dout_o  = req_dout_q;
        end else if (start_s) begin
            dreq_o  = 1'b1;
            daddr_o = {mem_wd_i[31:2], 2'b00};
            dwe_o   = is_store_s ? lanes_s : 4'b0000;
            dre_o   = is_load_s ? lanes_s : 4'b0000;
            dout_o  = is_store_s ? sdata_s : 32'h0000_0000;
        end else begin
            dreq_o  = 1'b0;
            daddr_o = 32'h0000_0000;
            dwe_o   = 4'b0000;
            dre_o   = 4'b0000;
            dout_o  = 32'h0000_0000;
        end
    end

    // Handshake FSM next state; MEM/WB receives a bubble on every cycle that retires nothing.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        flushed_d   = flushed_q;
        held_d      = held_q;
        req_addr_d  = req_addr_q;
        req_we_d    = req_we_q;
        req_re_d    = req_re_q;
        req_dout_d  = req_dout_q;
        wb_d        = '0;
        timeout_d   = 1'b0;
        stall_req_o = 1'b0;
`ifdef MEM_UNALIGNED_EXC_EN
        adel_d      = exc_s && is_load_s;
        ades_d      = exc_s && is_store_s;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_s) begin
                    state_d     = S_WAIT;
                    cnt_d       = 16'd0;
                    flushed_d   = 1'b0;
                    held_d      = cur_wb_s;
                    req_addr_d  = daddr_o;
                    req_we_d    = dwe_o;
                    req_re_d    = dre_o;
                    req_dout_d  = dout_o;
                    stall_req_o = 1'b1;
                end else if (mem_valid_i && !flush_i && !is_load_s && !is_store_s && !exc_s) begin
                    wb_d = cur_wb_s;
                end else begin
                    wb_d = '0;
                end
            end
            S_WAIT: begin
                flushed_d = flushed_q || flush_i;
                if (dack_i) begin
                    state_d = S_IDLE;
                    wb_d    = (flushed_q || flush_i) ? '0 : held_q;
                end else if (wd_fire_s) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d       = cnt_q + 16'd1;
                    stall_req_o = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and MEM/WB register update with synchronous reset.
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 16'd0;
            flushed_q  <= 1'b0;
            timeout_q  <= 1'b0;
            held_q     <= '0;
            wb_q       <= '0;
            req_addr_q <= 32'h0000_0000;
            req_we_q   <= 4'b0000;
            req_re_q   <= 4'b0000;
            req_dout_q <= 32'h0000_0000;
`ifdef MEM_UNALIGNED_EXC_EN
            adel_q     <= 1'b0;
            ades_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            flushed_q  <= flushed_d;
            timeout_q  <= timeout_d;
            held_q     <= held_d;
            wb_q       <= wb_d;
            req_addr_q <= req_addr_d;
            req_we_q   <= req_we_d;
            req_re_q   <= req_re_d;
            req_dout_q <= req_dout_d;
`ifdef MEM_UNALIGNED_EXC_EN
            adel_q     <= adel_d;
            ades_q     <= ades_d;
`endif
        end
    end

    assign timeout_o  = timeout_q;
    assign wb_aluop_o = wb_q.aluop;
    assign wb_wa_o    = wb_q.wa;
    assign wb_wreg_o  = wb_q.wreg;
    assign wb_whilo_o = wb_q.whilo;
    assign wb_mreg_o  = wb_q.mreg;
    assign wb_dreg_o  = wb_q.dreg;
    assign wb_dhilo_o = wb_q.dhilo;
    assign wb_dre_o   = wb_q.dre;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: scoreboard of expected MEM/WB contents plus request/stall/watchdog checks.
module tb_mem_stage;

    localparam logic [7:0] OP_LB   = 8'h90;
    localparam logic [7:0] OP_LBU  = 8'h91;
    localparam logic [7:0] OP_LH   = 8'h92;
    localparam logic [7:0] OP_LHU  = 8'h93;
    localparam logic [7:0] OP_LW   = 8'h94;
    localparam logic [7:0] OP_SB   = 8'h98;
    localparam logic [7:0] OP_SH   = 8'h99;
    localparam logic [7:0] OP_SW   = 8'h9A;
    localparam logic [7:0] OP_ADDU = 8'h19;

    logic        clk = 1'b0;
    logic        cpu_rst, mem_valid_i, mem_wreg_i, mem_whilo_i, mem_mreg_i, flush_i, dack_i;
    logic [7:0]  mem_aluop_i;
    logic [4:0]  mem_wa_i;
    logic [31:0] mem_wd_i, mem_din_i;
    logic [63:0] mem_hilo_i;
    logic        dreq_o, stall_req_o, timeout_o;
    logic [31:0] daddr_o, dout_o;
    logic [3:0]  dwe_o, dre_o;
    logic [7:0]  wb_aluop_o;
    logic [4:0]  wb_wa_o;
    logic        wb_wreg_o, wb_whilo_o, wb_mreg_o;
    logic [31:0] wb_dreg_o;
    logic [63:0] wb_dhilo_o;
    logic [3:0]  wb_dre_o;
`ifdef MEM_UNALIGNED_EXC_EN
    logic        adel_o, ades_o;
`endif

    logic [115:0] wb_vec;
    logic [115:0] sb_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    assign wb_vec = {wb_aluop_o, wb_wa_o, wb_wreg_o, wb_whilo_o, wb_mreg_o, wb_dreg_o, wb_dhilo_o, wb_dre_o};

    always #5 clk = ~clk;

    mem_stage #(.ACK_TIMEOUT(16)) dut (
        .cpu_clk_50M(clk), .cpu_rst(cpu_rst), .mem_valid_i(mem_valid_i), .mem_aluop_i(mem_aluop_i),
        .mem_wa_i(mem_wa_i), .mem_wreg_i(mem_wreg_i), .mem_whilo_i(mem_whilo_i), .mem_mreg_i(mem_mreg_i),
        .mem_wd_i(mem_wd_i), .mem_din_i(mem_din_i), .mem_hilo_i(mem_hilo_i), .flush_i(flush_i),
        .dreq_o(dreq_o), .daddr_o(daddr_o), .dwe_o(dwe_o), .dre_o(dre_o), .dout_o(dout_o),
        .dack_i(dack_i), .stall_req_o(stall_req_o), .timeout_o(timeout_o),
`ifdef MEM_UNALIGNED_EXC_EN
        .adel_o(adel_o), .ades_o(ades_o),
`endif
        .wb_aluop_o(wb_aluop_o), .wb_wa_o(wb_wa_o), .wb_wreg_o(wb_wreg_o), .wb_whilo_o(wb_whilo_o),
        .wb_mreg_o(wb_mreg_o), .wb_dreg_o(wb_dreg_o), .wb_dhilo_o(wb_dhilo_o), .wb_dre_o(wb_dre_o)
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input string tag);
        if (sb_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 128'd1, 128'd0);
        end else begin
            check_val({tag, "_wb"}, {12'h000, wb_vec}, {12'h000, sb_q.pop_front()});
        end
    endtask

    task automatic idle_inputs();
        mem_valid_i = 1'b0; mem_aluop_i = 8'h00; mem_wa_i = 5'd0; mem_wreg_i = 1'b0;
        mem_whilo_i = 1'b0; mem_mreg_i = 1'b0; mem_wd_i = 32'h0; mem_din_i = 32'h0;
        mem_hilo_i = 64'h0; flush_i = 1'b0; dack_i = 1'b0;
    endtask

    // Issue one memory op; ack arrives in wait cycle n (n>=1), so the stall lasts n cycles.
    task automatic mem_op(input string tag, input logic [7:0] op, input logic [31:0] addr, input logic [31:0] din,
                          input int n, input bit early, input bit flush_mid, input logic [31:0] exp_addr,
                          input logic [3:0] exp_we, input logic [3:0] exp_re, input logic [31:0] exp_dout);
        logic is_ld;
        int   stalls;
        is_ld = (exp_re != 4'b0000);
        mem_valid_i = 1'b1; mem_aluop_i = op; mem_wa_i = 5'd9; mem_wreg_i = is_ld; mem_whilo_i = 1'b0;
        mem_mreg_i = is_ld; mem_wd_i = addr; mem_din_i = din; mem_hilo_i = 64'hCAFE_F00D_1234_5678;
        sb_q.push_back(flush_mid ? 116'd0 : {op, 5'd9, is_ld, 1'b0, is_ld, addr, 64'hCAFE_F00D_1234_5678, exp_re});
        stalls = 0;
        for (int c = 0; c <= n; c++) begin
            dack_i  = (c == n) || (early && (c == 0));
            flush_i = flush_mid && (c == 1);
            @(negedge clk);
            if ((c == 0) || (c == n)) begin
                check_val({tag, "_dreq"}, {127'd0, dreq_o}, 128'd1);
                check_val({tag, "_daddr"}, {96'd0, daddr_o}, {96'd0, exp_addr});
                check_val({tag, "_dwe_dre"}, {120'd0, dwe_o, dre_o}, {120'd0, exp_we, exp_re});
                check_val({tag, "_dout"}, {96'd0, dout_o}, {96'd0, exp_dout});
            end
            if (stall_req_o) stalls++;
            tick();
        end
        dack_i = 1'b0; flush_i = 1'b0; mem_valid_i = 1'b0;
        pop_check(tag);
        check_val({tag, "_stall_cycles"}, 128'(stalls), 128'(n));
        @(negedge clk);
        check_val({tag, "_dreq_after"}, {127'd0, dreq_o}, 128'd0);
        tick();
    endtask

    initial begin
        int stalls;
        cpu_rst = 1'b1;
        idle_inputs();
        tick(); tick();
        @(negedge clk);
        check_val("reset_wb", {12'h000, wb_vec}, 128'd0);
        check_val("reset_ctl", {125'd0, dreq_o, stall_req_o, timeout_o}, 128'd0);
        cpu_rst = 1'b0;
        tick();

        // Non-memory stream: one-cycle pass-through, never stalls.
        for (int i = 0; i < 6; i++) begin
            mem_valid_i = 1'b1; mem_aluop_i = OP_ADDU; mem_wa_i = 5'(i + 1); mem_wreg_i = 1'b1;
            mem_whilo_i = i[0]; mem_mreg_i = 1'b0; mem_wd_i = $urandom; mem_hilo_i = {$urandom, $urandom};
            sb_q.push_back({OP_ADDU, 5'(i + 1), 1'b1, i[0], 1'b0, mem_wd_i, mem_hilo_i, 4'b0000});
            @(negedge clk);
            check_val("addu_stall", {126'd0, stall_req_o, dreq_o}, 128'd0);
            tick();
            pop_check("addu");
        end
        mem_valid_i = 1'b0;
        sb_q.push_back(116'd0);
        tick();
        pop_check("bubble_invalid");
        mem_valid_i = 1'b1; flush_i = 1'b1;
        sb_q.push_back(116'd0);
        tick();
        pop_check("bubble_flush");
        idle_inputs();
        tick();

        mem_op("sw",   OP_SW,  32'h100, 32'h11223344, 3, 1'b0, 1'b0, 32'h100, 4'b1111, 4'b0000, 32'h44332211);
        mem_op("sb",   OP_SB,  32'h103, 32'h000000AB, 1, 1'b0, 1'b0, 32'h100, 4'b0001, 4'b0000, 32'hABABABAB);
        mem_op("lh",   OP_LH,  32'h102, 32'h0,        2, 1'b1, 1'b0, 32'h100, 4'b0000, 4'b0011, 32'h0);
        mem_op("lb",   OP_LB,  32'h201, 32'h0,        1, 1'b0, 1'b0, 32'h200, 4'b0000, 4'b0100, 32'h0);
        mem_op("lbu",  OP_LBU, 32'h203, 32'h0,        2, 1'b0, 1'b0, 32'h200, 4'b0000, 4'b0001, 32'h0);
        mem_op("sh0",  OP_SH,  32'h300, 32'h00001234, 2, 1'b0, 1'b0, 32'h300, 4'b1100, 4'b0000, 32'h34123412);
        mem_op("sh2",  OP_SH,  32'h302, 32'hFFFF5678, 1, 1'b0, 1'b0, 32'h300, 4'b0011, 4'b0000, 32'h78567856);
        mem_op("lw",   OP_LW,  32'h104, 32'h0,        4, 1'b0, 1'b0, 32'h104, 4'b0000, 4'b1111, 32'h0);
        mem_op("lwfl", OP_LW,  32'h108, 32'h0,        3, 1'b0, 1'b1, 32'h108, 4'b0000, 4'b1111, 32'h0);
`ifndef MEM_UNALIGNED_EXC_EN
        mem_op("lwun", OP_LW,  32'h101, 32'h0,        1, 1'b0, 1'b0, 32'h100, 4'b0000, 4'b1111, 32'h0);
        mem_op("lhun", OP_LHU, 32'h103, 32'h0,        1, 1'b0, 1'b0, 32'h100, 4'b0000, 4'b0011, 32'h0);
`else
        mem_valid_i = 1'b1; mem_aluop_i = OP_LW; mem_wa_i = 5'd3; mem_wreg_i = 1'b1; mem_mreg_i = 1'b1;
        mem_wd_i = 32'h101;
        @(negedge clk);
        check_val("adel_noreq", {126'd0, dreq_o, stall_req_o}, 128'd0);
        tick();
        mem_valid_i = 1'b0;
        @(negedge clk);
        check_val("adel_pulse", {126'd0, adel_o, ades_o}, 128'd2);
        check_val("adel_wb", {12'h000, wb_vec}, 128'd0);
        tick();
        @(negedge clk);
        check_val("adel_clear", {127'd0, adel_o}, 128'd0);
        tick();
`endif

        // Watchdog: no ack, stall lasts ACK_TIMEOUT cycles, then timeout pulse and bubble.
        mem_valid_i = 1'b1; mem_aluop_i = OP_LW; mem_wa_i = 5'd7; mem_wreg_i = 1'b1; mem_mreg_i = 1'b1;
        mem_wd_i = 32'h500;
        stalls = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!stall_req_o) break;
            stalls++;
            tick();
        end
        check_val("wd_stall_cycles", 128'(stalls), 128'd16);
        tick();
        mem_valid_i = 1'b0;
        @(negedge clk);
        check_val("wd_timeout", {125'd0, timeout_o, dreq_o, stall_req_o}, 128'd4);
        check_val("wd_wb", {12'h000, wb_vec}, 128'd0);
        tick();
        @(negedge clk);
        check_val("wd_pulse_end", {127'd0, timeout_o}, 128'd0);
        tick();

        // Reset in the middle of a wait.
        mem_valid_i = 1'b1; mem_aluop_i = OP_SW; mem_wd_i = 32'h600; mem_din_i = 32'h55;
        tick(); tick();
        @(negedge clk);
        check_val("rst_pre_wait", {127'd0, dreq_o}, 128'd1);
        tick();
        cpu_rst = 1'b1;
        tick(); tick();
        @(negedge clk);
        check_val("rst_mid_ctl", {125'd0, dreq_o, stall_req_o, timeout_o}, 128'd0);
        check_val("rst_mid_wb", {12'h000, wb_vec}, 128'd0);
        mem_valid_i = 1'b0;
        tick();
        cpu_rst = 1'b0;
        mem_valid_i = 1'b1; mem_aluop_i = OP_ADDU; mem_wa_i = 5'd21; mem_wreg_i = 1'b1; mem_mreg_i = 1'b0;
        mem_whilo_i = 1'b0; mem_wd_i = 32'hDEAD_BEEF; mem_hilo_i = 64'h1;
        sb_q.push_back({OP_ADDU, 5'd21, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 64'h1, 4'b0000});
        tick();
        pop_check("post_rst_addu");
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
